// File: rtl/operand_scoreboard.sv
// ---------------------------------------------------------------------------
// operand_scoreboard
//   Decode-stage operand unit. It holds a banked register file (bank 0 = gpr,
//   bank 1 = fpr) with NRP combinational read ports and one writeback port.
//   It also keeps a per-register scoreboard of in-flight producers. The
//   scoreboard holds a pending bit and an advisory latency countdown.
//   iss_ready stalls decode until every used source and the destination are
//   free of hazards.
//
//   Optional feature macro: OPSB_WB_BYPASS_EN
//     defined   : a writeback forwards to the read ports in the same cycle,
//                 and the destination of that writeback counts as free for
//                 the WAW check.
//     undefined : no forwarding. A source stays busy through its writeback
//                 cycle.
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset (clears the scoreboard only)
//   rd_addr    NRP x {bank,idx} source addresses
//   rd_used    per-port "is a real source" flags
//   rd_data    NRP x XLEN operand values (gpr[0] reads zero)
//   rd_busy    per-port unresolved-producer flag
//   rd_wait    NRP x WAITW remaining countdown of each source's producer
//   iss_valid  decode presents an instruction
//   iss_wen    instruction writes a register
//   iss_dst    destination {bank,idx}
//   iss_lat    producer latency estimate
//   iss_ready  instruction may issue this cycle
//   wb_en      writeback strobe
//   wb_addr    writeback destination
//   wb_data    writeback value
//   flush      drop every pending mark
//   dbg_addr   debug read address
//   dbg_data   raw array contents at dbg_addr (no forwarding, no gpr[0] masking)
// ---------------------------------------------------------------------------
module operand_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 64,
  parameter int NRP   = 2,
  parameter int WAITW = 5,
  localparam int AW   = 1 + $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NRP*AW-1:0]     rd_addr,
  input  logic [NRP-1:0]        rd_used,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [NRP-1:0]        rd_busy,
  output logic [NRP*WAITW-1:0]  rd_wait,
  input  logic                  iss_valid,
  input  logic                  iss_wen,
  input  logic [AW-1:0]         iss_dst,
  input  logic [WAITW-1:0]      iss_lat,
  output logic                  iss_ready,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  localparam int NTOT = 2 * NREG;

`ifdef OPSB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // The array is deliberately left out of reset. Its power-up contents come
  // from the device configuration.
  logic [XLEN-1:0]  regs [NTOT];
  logic [NTOT-1:0]  pend;
  logic [WAITW-1:0] cnt  [NTOT];

  logic [NRP-1:0] bypass_hit;
  logic           wb_fwd_dst;
  logic           dst_busy;
  logic           issue_set;

  // Read ports. Address 0 is gpr[0], which is hard-wired to zero and never
  // forwarded.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0] src;
    assign src           = rd_addr[p*AW +: AW];
    assign bypass_hit[p] = BYPASS && wb_en && (wb_addr == src) && (src != '0);
    assign rd_data[p*XLEN +: XLEN] = (src == '0)    ? '0      :
                                     bypass_hit[p]  ? wb_data : regs[src];
    assign rd_busy[p]    = pend[src] && !bypass_hit[p];
    assign rd_wait[p*WAITW +: WAITW] = pend[src] ? cnt[src] : '0;
  end

  // WAW guard: a pending destination blocks issue. With forwarding enabled, a
  // writeback landing on that destination in this same cycle frees it early.
  assign wb_fwd_dst = BYPASS && wb_en && (wb_addr == iss_dst);
  assign dst_busy   = iss_wen && (iss_dst != '0) && pend[iss_dst] && !wb_fwd_dst;
  assign iss_ready  = !(|(rd_busy & rd_used)) && !dst_busy;

  // Flush suppresses the mark of an instruction issuing in the same cycle.
  assign issue_set  = iss_valid && iss_ready && iss_wen && (iss_dst != '0) && !flush;

  assign dbg_data   = regs[dbg_addr];

  // Writeback data path. Writes to gpr[0] are dropped, and writes are also
  // ignored while reset is asserted. Flush does not block data writes.
  always_ff @(posedge clk) begin
    if (rstn && wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard update, in priority order: reset/flush clear, then a new issue
  // mark (which wins over a same-cycle writeback), then writeback clear, then
  // the countdown. The countdown is advisory only. It never clears pend.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NTOT; i++) begin
      if (!rstn || flush) begin
        pend[i] <= 1'b0;
        cnt[i]  <= '0;
      end else if (issue_set && (iss_dst == AW'(i))) begin
        pend[i] <= 1'b1;
        cnt[i]  <= iss_lat;
      end else if (wb_en && (wb_addr == AW'(i)) && pend[i]) begin
        pend[i] <= 1'b0;
        cnt[i]  <= '0;
      end else if (pend[i] && (cnt[i] != '0)) begin
        cnt[i]  <= cnt[i] - WAITW'(1);
      end
    end
  end

endmodule

// File: tb/tb_operand_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_operand_scoreboard
//   Directed scenarios plus a randomized run, all checked against a
//   behavioural model of the register file and scoreboard kept in this file.
//   Inputs change 1 ns after each rising edge. Outputs are compared at the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_operand_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREG  = 64;
  localparam int NRP   = 2;
  localparam int WAITW = 5;
  localparam int AW    = 7;
  localparam int NTOT  = 128;

`ifdef OPSB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk;
  logic                 rstn;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP-1:0]       rd_used;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP-1:0]       rd_busy;
  logic [NRP*WAITW-1:0] rd_wait;
  logic                 iss_valid;
  logic                 iss_wen;
  logic [AW-1:0]        iss_dst;
  logic [WAITW-1:0]     iss_lat;
  logic                 iss_ready;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 flush;
  logic [AW-1:0]        dbg_addr;
  logic [XLEN-1:0]      dbg_data;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [XLEN-1:0] m_mem  [NTOT];
  bit              m_pend [NTOT];
  int              m_cnt  [NTOT];

  operand_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .WAITW(WAITW)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_used(rd_used),
    .rd_data(rd_data), .rd_busy(rd_busy), .rd_wait(rd_wait),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst),
    .iss_lat(iss_lat), .iss_ready(iss_ready), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model queries ----------------
  function automatic logic [AW-1:0] src(int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic bit m_hit(logic [AW-1:0] a);
    return BYP && wb_en && (wb_addr == a) && (a != 0);
  endfunction

  function automatic logic [XLEN-1:0] m_data(int p);
    logic [AW-1:0] a;
    a = src(p);
    if (a == 0) return '0;
    if (m_hit(a)) return wb_data;
    return m_mem[a];
  endfunction

  function automatic bit m_busy(int p);
    return m_pend[src(p)] && !m_hit(src(p));
  endfunction

  function automatic int m_wait(int p);
    return m_pend[src(p)] ? m_cnt[src(p)] : 0;
  endfunction

  function automatic bit m_ready();
    for (int p = 0; p < NRP; p++)
      if (rd_used[p] && m_busy(p)) return 1'b0;
    if (iss_wen && iss_dst != 0 && m_pend[iss_dst] && !(BYP && wb_en && wb_addr == iss_dst))
      return 1'b0;
    return 1'b1;
  endfunction

  // Applies the inputs presented this cycle to the model at the clock edge.
  task automatic model_update();
    bit set;
    if (!rstn) begin
      for (int i = 0; i < NTOT; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
    end else begin
      set = iss_valid && m_ready() && iss_wen && iss_dst != 0 && !flush;
      for (int i = 0; i < NTOT; i++)
        if (m_pend[i] && m_cnt[i] > 0) m_cnt[i]--;
      if (wb_en && m_pend[wb_addr]) begin m_pend[wb_addr] = 0; m_cnt[wb_addr] = 0; end
      if (flush)
        for (int i = 0; i < NTOT; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
      if (set) begin m_pend[iss_dst] = 1; m_cnt[iss_dst] = int'(iss_lat); end
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_wen = 0; wb_en = 0; flush = 0; rd_used = '0;
  endtask

  task automatic set_src(int p, logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic issue(logic [AW-1:0] dst, logic [WAITW-1:0] lat);
    idle_inputs();
    iss_valid = 1; iss_wen = 1; iss_dst = dst; iss_lat = lat;
    advance();
    idle_inputs();
  endtask

  task automatic writeback(logic [AW-1:0] a, logic [XLEN-1:0] d);
    idle_inputs();
    wb_en = 1; wb_addr = a; wb_data = d;
    advance();
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    advance(); advance();
    rstn = 1;
    set_src(0, 7'd5); set_src(1, 7'd70); rd_used = 2'b11;
    iss_wen = 1; iss_dst = 7'd9;
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 00", rd_busy); end
    n_cmp++;
    if (rd_wait !== '0) begin n_fail++; $display("[TB] FAIL reset_wait: got %h expected 0", rd_wait); end
    n_cmp++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", iss_ready); end
    advance();
    // Give every register a known value before checking any data.
    for (int a = 1; a < NTOT; a++) writeback(AW'(a), $urandom);
    for (int k = 0; k < 8; k++) begin
      dbg_addr = AW'($urandom_range(1, NTOT-1));
      #1;
      n_cmp++;
      if (dbg_data !== m_mem[dbg_addr]) begin
        n_fail++; $display("[TB] FAIL fill_dbg[%0d]: got %h expected %h", dbg_addr, dbg_data, m_mem[dbg_addr]);
      end
    end
  endtask

  task automatic test_gpr0();
    idle_inputs();
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD; set_src(0, 0); rd_used = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (rd_data[XLEN-1:0] !== '0) begin n_fail++; $display("[TB] FAIL gpr0_wbcycle: got %h expected 0", rd_data[XLEN-1:0]); end
    advance();
    wb_en = 0; iss_valid = 1; iss_wen = 1; iss_dst = 0; iss_lat = 5;
    @(negedge clk);
    n_cmp++;
    if (rd_data[XLEN-1:0] !== '0) begin n_fail++; $display("[TB] FAIL gpr0_data: got %h expected 0", rd_data[XLEN-1:0]); end
    n_cmp++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL gpr0_ready: got %b expected 1", iss_ready); end
    advance();
    iss_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL gpr0_busy: got %b expected 0", rd_busy[0]); end
    advance();
  endtask

  task automatic test_countdown();
    int exp_w[5] = '{3, 2, 1, 0, 0};
    logic [XLEN-1:0] exp_d;
    issue(7'd5, 5'd3);
    set_src(0, 7'd5); rd_used = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (int'(rd_wait[WAITW-1:0]) !== exp_w[k]) begin
        n_fail++; $display("[TB] FAIL countdown_wait[%0d]: got %0d expected %0d", k, rd_wait[WAITW-1:0], exp_w[k]);
      end
      n_cmp++;
      if (rd_busy[0] !== 1'b1 || iss_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL countdown_stall[%0d]: got busy=%b ready=%b expected busy=1 ready=0", k, rd_busy[0], iss_ready);
      end
      advance();
    end
    wb_en = 1; wb_addr = 7'd5; wb_data = 32'h1234;
    exp_d = BYP ? 32'h1234 : m_mem[5];
    @(negedge clk);
    n_cmp++;
    if (rd_busy[0] !== !BYP) begin n_fail++; $display("[TB] FAIL wb_cycle_busy: got %b expected %b", rd_busy[0], !BYP); end
    n_cmp++;
    if (rd_data[XLEN-1:0] !== exp_d) begin n_fail++; $display("[TB] FAIL wb_cycle_data: got %h expected %h", rd_data[XLEN-1:0], exp_d); end
    advance();
    wb_en = 0;
    @(negedge clk);
    n_cmp++;
    if (rd_data[XLEN-1:0] !== 32'h1234 || rd_busy[0] !== 1'b0 || rd_wait[WAITW-1:0] !== '0) begin
      n_fail++; $display("[TB] FAIL after_wb: got data=%h busy=%b wait=%0d expected 1234/0/0", rd_data[XLEN-1:0], rd_busy[0], rd_wait[WAITW-1:0]);
    end
    advance();
  endtask

  task automatic test_banks();
    issue(7'd69, 5'd4);
    set_src(0, 7'd5); set_src(1, 7'd69); rd_used = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b10) begin n_fail++; $display("[TB] FAIL banks_busy: got %b expected 10", rd_busy); end
    n_cmp++;
    if (rd_wait[2*WAITW-1:WAITW] !== 5'd4) begin n_fail++; $display("[TB] FAIL banks_wait: got %0d expected 4", rd_wait[2*WAITW-1:WAITW]); end
    advance();
    writeback(7'd69, $urandom);
    rd_used = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("[TB] FAIL banks_clear: got %b expected 00", rd_busy); end
    advance();
  endtask

  task automatic test_waw();
    issue(7'd7, 5'd2);
    iss_valid = 1; iss_wen = 1; iss_dst = 7'd7; iss_lat = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (iss_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_stall[%0d]: got %b expected 0", k, iss_ready); end
      advance();
    end
    wb_en = 1; wb_addr = 7'd7; wb_data = $urandom;
    @(negedge clk);
    n_cmp++;
    if (iss_ready !== BYP) begin n_fail++; $display("[TB] FAIL waw_wbcycle: got %b expected %b", iss_ready, BYP); end
    advance();
    wb_en = 0; iss_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (iss_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL waw_after: got %b expected %b", iss_ready, m_ready()); end
    advance();
    writeback(7'd7, $urandom);
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] old;
    issue(7'd3, 5'd6);
    issue(7'd73, 5'd2);
    flush = 1; iss_valid = 1; iss_wen = 1; iss_dst = 7'd4; iss_lat = 5'd5;
    @(negedge clk);
    n_cmp++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_cycle_ready: got %b expected 1", iss_ready); end
    advance();
    idle_inputs();
    set_src(0, 7'd3); set_src(1, 7'd73); rd_used = 2'b11;
    iss_wen = 1; iss_dst = 7'd4;
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_wait !== '0 || iss_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_clear: got busy=%b wait=%h ready=%b expected 00/0/1", rd_busy, rd_wait, iss_ready);
    end
    advance();
    issue(7'd3, 5'd8);
    old = m_mem[10];
    rstn = 0; wb_en = 1; wb_addr = 7'd10; wb_data = ~old;
    advance();
    rstn = 1; idle_inputs();
    set_src(0, 7'd3); rd_used = 2'b01; dbg_addr = 7'd10;
    @(negedge clk);
    n_cmp++;
    if (dbg_data !== old) begin n_fail++; $display("[TB] FAIL reset_retain: got %h expected %h", dbg_data, old); end
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_midop_busy: got %b expected 0", rd_busy[0]); end
    advance();
  endtask

  // Addresses drawn from 16 registers (8 per bank) so hazards occur often.
  function automatic logic [AW-1:0] rand_reg();
    return {1'($urandom_range(0, 1)), 3'b000, 3'($urandom_range(0, 7))};
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rstn      = ($urandom_range(0, 99) != 0);
      set_src(0, rand_reg()); set_src(1, rand_reg());
      rd_used   = 2'($urandom);
      iss_valid = ($urandom_range(0, 9) < 6);
      iss_wen   = ($urandom_range(0, 9) < 7);
      iss_dst   = rand_reg();
      iss_lat   = 5'($urandom_range(0, 15));
      wb_en     = ($urandom_range(0, 9) < 4);
      wb_addr   = rand_reg();
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 99) < 3);
      dbg_addr  = rand_reg();
      @(negedge clk);
      for (int p = 0; p < NRP; p++) begin
        n_cmp++;
        if (rd_data[p*XLEN +: XLEN] !== m_data(p) || rd_busy[p] !== m_busy(p) || int'(rd_wait[p*WAITW +: WAITW]) !== m_wait(p)) begin
          n_fail++;
          $display("[TB] FAIL rand_port%0d c=%0d: got data=%h busy=%b wait=%0d expected %h/%b/%0d", p, c,
                   rd_data[p*XLEN +: XLEN], rd_busy[p], rd_wait[p*WAITW +: WAITW], m_data(p), m_busy(p), m_wait(p));
        end
      end
      n_cmp++;
      if (iss_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, iss_ready, m_ready()); end
      if (dbg_addr != 0) begin
        n_cmp++;
        if (dbg_data !== m_mem[dbg_addr]) begin n_fail++; $display("[TB] FAIL rand_dbg c=%0d: got %h expected %h", c, dbg_data, m_mem[dbg_addr]); end
      end
      advance();
    end
    rstn = 1;
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < NTOT; i++) begin m_mem[i] = '0; m_pend[i] = 0; m_cnt[i] = 0; end
    rstn = 0; rd_addr = '0; iss_dst = '0; iss_lat = '0; wb_addr = '0; wb_data = '0; dbg_addr = '0;
    idle_inputs();
    test_reset();
    test_gpr0();
    test_countdown();
    test_banks();
    test_waw();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
